// File: rtl/dds_arith_pkg.sv
// Shared arithmetic definitions for the DDS datapath: default operand width,
// divider state encoding and the divider iteration-counter width.
package dds_arith_pkg;

  // Default operand width, shared by the shift-add multiplier and the divider.
  localparam int DDS_M = 12;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  // Iteration counter width: must hold the values 0..width.
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DDS_M);

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int m = 12
) (
  input  logic [m:0]   r_i,      // partial remainder, r_i < {0,d_i}
  input  logic         q_msb_i,  // next dividend bit shifted in
  input  logic [m-1:0] d_i,      // divisor
  output logic [m:0]   r_o,      // new partial remainder
  output logic         qbit_o    // quotient bit produced by this step
);

  logic [m:0] t;

  // Shift, compare, conditionally subtract. r_i[m] stays 0 while the
  // remainder is below the divisor; should it ever be set, the shifted value
  // is certainly >= divisor, so it simply forces the subtract.
  always_comb begin
    t      = {r_i[m-1:0], q_msb_i};
    qbit_o = r_i[m] | (t >= {1'b0, d_i});
    r_o    = qbit_o ? (t - {1'b0, d_i}) : t;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2m-bit dividend / m-bit divisor, one quotient
// bit per clock, start/done handshake.
//
// Handshake: start is sampled only in IDLE; the accepting edge raises busy.
// busy falls on the same edge that raises done. done is a one-cycle pulse,
// and quotient/remainder/div_zero/overflow are valid while done is high and
// hold until the next result or reset. A start seen while done is high is
// accepted, because the controller is already back in IDLE.
module seq_divider
  import dds_arith_pkg::*;
#(
  parameter int m = DDS_M
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*m-1:0] dividend,
  input  logic [m-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [m-1:0]   quotient,
  output logic [m-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow,
  output logic [1:0]     dbg_state
);

  localparam int CW = div_cnt_w(m);

  div_state_e    state_q, state_d;
  logic [m-1:0]  d_q, d_d;
  logic [m:0]    r_q, r_d;
  logic [m-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_pend_q, dz_pend_d;
  logic          ov_pend_q, ov_pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [m-1:0]  quot_q, quot_d;
  logic [m-1:0]  rem_q, rem_d;
  logic          div_zero_q, div_zero_d;
  logic          overflow_q, overflow_d;

  logic [m:0]    step_r;
  logic          step_qbit;
  logic [m-1:0]  dvd_hi;

  assign dvd_hi = dividend[2*m-1:m];

  div_step #(.m(m)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[m-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .qbit_o  (step_qbit)
  );

  // State and datapath registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      r_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      dz_pend_q  <= 1'b0;
      ov_pend_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      r_q        <= r_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      dz_pend_q  <= dz_pend_d;
      ov_pend_q  <= ov_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state changes it.
  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    r_d        = r_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    dz_pend_d  = dz_pend_q;
    ov_pend_d  = ov_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_d       = divisor;
          r_d       = {1'b0, dvd_hi};
          q_d       = dividend[m-1:0];
          cnt_d     = '0;
          busy_d    = 1'b1;
          dz_pend_d = (divisor == '0);
          // Quotient fits in m bits only when the upper half is below the divisor.
          ov_pend_d = (divisor != '0) && (dvd_hi >= divisor);
          if ((divisor == '0) || (dvd_hi >= divisor)) begin
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        r_d   = step_r;
        q_d   = {q_q[m-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(m - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        div_zero_d = dz_pend_q;
        overflow_d = ov_pend_q;
        if (dz_pend_q) begin
          // Q still holds the untouched low dividend half.
          quot_d = '1;
          rem_d  = q_q;
        end else if (ov_pend_q) begin
          quot_d = '1;
          rem_d  = '0;
        end else begin
          quot_d = q_q;
          rem_d  = r_q[m-1:0];
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed vector table, randomised round-trip and
// quotient/remainder checks, and control corner cases (start while busy,
// back-to-back starts, reset mid-computation).
module tb_seq_divider;
  import dds_arith_pkg::*;

  localparam int M = 12;
  localparam int W = 2 * M;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   dividend;
  logic [M-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [M-1:0]   quotient;
  logic [M-1:0]   remainder;
  logic           div_zero;
  logic           overflow;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [M-1:0] dvs;
    logic [M-1:0] q;
    logic [M-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  vec_t vecs[10];

  seq_divider #(.m(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one division and wait (bounded) for done. lat = edges after the
  // accept edge at which done is first seen, -1 on timeout. busy_ok is
  // cleared if busy is not high on every sample before done, or not low with done.
  task automatic run_div(input logic [W-1:0] dvd, input logic [M-1:0] dvs,
                         output int lat, output bit busy_ok);
    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom());
    divisor  = M'($urandom());
    busy_ok  = (busy === 1'b1) && (done === 1'b0);
    lat      = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = e;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    bit          bok;
    int          exp_lat;
    int          a, b, hi, lo, dv;
    int          done_cnt;
    int          done_at[$];
    logic [M-1:0] cap_q, cap_r;
    logic        cap_dz;

    vecs[0] = '{dvd: 24'd100,     dvs: 12'd7,     q: 12'd14,    r: 12'd2,     dz: 1'b0, ov: 1'b0};
    vecs[1] = '{dvd: 24'hFFEFFF,  dvs: 12'hFFF,   q: 12'hFFF,   r: 12'hFFE,   dz: 1'b0, ov: 1'b0};
    vecs[2] = '{dvd: 24'h000123,  dvs: 12'h000,   q: 12'hFFF,   r: 12'h123,   dz: 1'b1, ov: 1'b0};
    vecs[3] = '{dvd: 24'h005000,  dvs: 12'h004,   q: 12'hFFF,   r: 12'h000,   dz: 1'b0, ov: 1'b1};
    vecs[4] = '{dvd: 24'h000000,  dvs: 12'h001,   q: 12'h000,   r: 12'h000,   dz: 1'b0, ov: 1'b0};
    vecs[5] = '{dvd: 24'h000FFF,  dvs: 12'h001,   q: 12'hFFF,   r: 12'h000,   dz: 1'b0, ov: 1'b0};
    vecs[6] = '{dvd: 24'h001000,  dvs: 12'h001,   q: 12'hFFF,   r: 12'h000,   dz: 1'b0, ov: 1'b1};
    vecs[7] = '{dvd: 24'h123456,  dvs: 12'h000,   q: 12'hFFF,   r: 12'h456,   dz: 1'b1, ov: 1'b0};
    vecs[8] = '{dvd: 24'h01E240,  dvs: 12'h100,   q: 12'h1E2,   r: 12'h040,   dz: 1'b0, ov: 1'b0};
    vecs[9] = '{dvd: 24'h7FFFFF,  dvs: 12'h800,   q: 12'hFFF,   r: 12'h7FF,   dz: 1'b0, ov: 1'b0};

    // Reset
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy",      32'(busy),      32'd0);
    chk("reset done",      32'(done),      32'd0);
    chk("reset quotient",  32'(quotient),  32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_zero",  32'(div_zero),  32'd0);
    chk("reset overflow",  32'(overflow),  32'd0);
    chk("reset state",     32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].dvd, vecs[i].dvs, lat, bok);
      exp_lat = (vecs[i].dz || vecs[i].ov) ? 1 : M + 1;
      chk($sformatf("vec%0d latency", i),   32'(lat),       32'(exp_lat));
      chk($sformatf("vec%0d busy", i),      32'(bok),       32'd1);
      chk($sformatf("vec%0d quotient", i),  32'(quotient),  32'(vecs[i].q));
      chk($sformatf("vec%0d remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("vec%0d div_zero", i),  32'(div_zero),  32'(vecs[i].dz));
      chk($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vecs[i].ov));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done pulse", i), 32'(done),     32'd0);
      chk($sformatf("vec%0d hold q", i),     32'(quotient), 32'(vecs[i].q));
    end

    // Round trip: (a*b)/b == a, remainder 0
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(1, 4095);
      b = $urandom_range(1, 4095);
      run_div(W'(a * b), M'(b), lat, bok);
      chk("rt latency",   32'(lat),       32'(M + 1));
      chk("rt quotient",  32'(quotient),  32'(a));
      chk("rt remainder", 32'(remainder), 32'd0);
    end

    // Random in-range pairs against integer division
    for (int i = 0; i < 200; i++) begin
      b  = $urandom_range(1, 4095);
      hi = $urandom_range(0, b - 1);
      lo = $urandom_range(0, 4095);
      dv = hi * 4096 + lo;
      run_div(W'(dv), M'(b), lat, bok);
      chk("rnd busy",      32'(bok),       32'd1);
      chk("rnd quotient",  32'(quotient),  32'(dv / b));
      chk("rnd remainder", 32'(remainder), 32'(dv % b));
      chk("rnd overflow",  32'(overflow),  32'd0);
    end

    // start pulsed during CALC is ignored
    @(negedge clk);
    start = 1'b1; dividend = 24'd100; divisor = 12'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 24'h000123; divisor = 12'h000;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; cap_q = '0; cap_r = '0; cap_dz = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        cap_q = quotient; cap_r = remainder; cap_dz = div_zero;
      end
    end
    chk("ignore start done count", 32'(done_cnt), 32'd1);
    chk("ignore start quotient",   32'(cap_q),    32'd14);
    chk("ignore start remainder",  32'(cap_r),    32'd2);
    chk("ignore start div_zero",   32'(cap_dz),   32'd0);

    // start held high: back-to-back results every M+2 cycles
    @(negedge clk);
    start = 1'b1; dividend = 24'd100; divisor = 12'd7;
    @(posedge clk);
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_at.push_back(e);
        chk("b2b quotient", 32'(quotient), 32'd14);
      end
    end
    chk("b2b done count", 32'(done_at.size()), 32'd3);
    if (done_at.size() == 3) begin
      chk("b2b first done",  32'(done_at[0]), 32'(M + 1));
      chk("b2b second done", 32'(done_at[1]), 32'(2 * M + 3));
      chk("b2b third done",  32'(done_at[2]), 32'(3 * M + 5));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);

    // Reset at iteration 5 aborts without done
    @(negedge clk);
    start = 1'b1; dividend = 24'd100; divisor = 12'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort busy",      32'(busy),      32'd0);
    chk("abort done",      32'(done),      32'd0);
    chk("abort quotient",  32'(quotient),  32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    chk("abort div_zero",  32'(div_zero),  32'd0);
    chk("abort overflow",  32'(overflow),  32'd0);
    chk("abort state",     32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    chk("abort no activity", 32'(done_cnt), 32'd0);
    run_div(24'hFFEFFF, 12'hFFF, lat, bok);
    chk("post-abort latency",   32'(lat),       32'(M + 1));
    chk("post-abort quotient",  32'(quotient),  32'hFFF);
    chk("post-abort remainder", 32'(remainder), 32'hFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
